// File: rtl/sig_capture_pkg.sv
// Shared types and default sizes for the sig_capture trigger/capture sink.
package sig_capture_pkg;

  localparam int CAP_WIDTH      = 8;
  localparam int CAP_ADDR_WIDTH = 8;
  localparam int CAP_DECIM_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/sig_capture_cap_ram.sv
// cap_ram: simple dual-port synchronous RAM with one write port and one
// registered read port. A same-address read and write in one cycle returns
// the old contents (read-before-write). Contents are never cleared; only the
// read register is reset.
module cap_ram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  logic [WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

  // Write port: store one sample when enabled.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: registered every cycle; sees pre-write contents on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rd_data <= '0;
    end else begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/sig_capture.sv
// sig_capture: watches a qualified sample stream for a rising crossing of
// trig_level, then records a DEPTH-sample window into cap_ram for readback.
// Optional feature macro CAP_DECIM_EN adds input decim[3:0]: in CAPTURE only
// every (decim+1)-th en sample is stored; trigger detection is unaffected.
//
// Handshake: en is a plain valid strobe with no ready; din is consumed on
// every clock where en=1, and cycles with en=0 change nothing. arm is a
// single-cycle request honoured only in IDLE and DONE.
module sig_capture
  import sig_capture_pkg::*;
#(
  parameter int WIDTH      = CAP_WIDTH,
  parameter int ADDR_WIDTH = CAP_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WIDTH-1:0]      din,
  input  logic                  arm,
  input  logic [WIDTH-1:0]      trig_level,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
`ifdef CAP_DECIM_EN
  input  logic [CAP_DECIM_W-1:0] decim,
`endif
  output logic [WIDTH-1:0]      rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_count,
  output cap_state_t            dbg_state
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

  cap_state_t            r_state;
  cap_state_t            w_next_state;
  logic [WIDTH-1:0]      r_prev;
  logic                  r_prev_valid;
  logic [ADDR_WIDTH:0]   r_wr_count;
  logic                  w_trig;
  logic                  w_keep;
  logic                  w_we;
  logic                  w_store;
  logic                  w_enter_armed;
  logic [ADDR_WIDTH-1:0] w_wr_addr;

  // Rising crossing: previous sample strictly below level, current at/above.
  assign w_trig = r_prev_valid && (r_prev < trig_level) && (din >= trig_level);

`ifdef CAP_DECIM_EN
  logic [CAP_DECIM_W-1:0] r_dec_cnt;

  assign w_keep = (r_dec_cnt == decim);

  // Decimation phase: restarts at the trigger, wraps each time a sample is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec_cnt <= '0;
    end else if (r_state == ARMED && en && w_trig) begin
      r_dec_cnt <= '0;
    end else if (r_state == CAPTURE && en) begin
      r_dec_cnt <= w_keep ? '0 : r_dec_cnt + CAP_DECIM_W'(1);
    end
  end
`else
  assign w_keep = 1'b1;
`endif

  // Next-state and RAM write control.
  always_comb begin
    w_next_state  = r_state;
    w_we          = 1'b0;
    w_store       = 1'b0;
    w_enter_armed = 1'b0;
    w_wr_addr     = '0;
    case (r_state)
      IDLE: begin
        if (arm) begin
          w_next_state  = ARMED;
          w_enter_armed = 1'b1;
        end
      end
      ARMED: begin
        if (en && w_trig) begin
          w_next_state = CAPTURE;
          w_we         = 1'b1;
          w_wr_addr    = '0;
        end
      end
      CAPTURE: begin
        if (en && w_keep) begin
          w_we      = 1'b1;
          w_store   = 1'b1;
          w_wr_addr = r_wr_count[ADDR_WIDTH-1:0];
          if (r_wr_count == LAST_IDX) begin
            w_next_state = DONE;
          end
        end
      end
      DONE: begin
        if (arm) begin
          w_next_state  = ARMED;
          w_enter_armed = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Previous-sample tracking and stored-sample count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_wr_count   <= '0;
    end else if (w_enter_armed) begin
      r_prev_valid <= 1'b0;
      r_wr_count   <= '0;
    end else if (r_state == ARMED && en) begin
      r_prev       <= din;
      r_prev_valid <= 1'b1;
      if (w_trig) begin
        r_wr_count <= CNT_ONE;
      end
    end else if (w_store) begin
      r_wr_count <= r_wr_count + CNT_ONE;
    end
  end

  cap_ram #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we && !rst),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (din),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  assign busy      = (r_state == ARMED) || (r_state == CAPTURE);
  assign done      = (r_state == DONE);
  assign wr_count  = r_wr_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sig_capture.sv
// Testbench for sig_capture (WIDTH=8, ADDR_WIDTH=4, DEPTH=16).
// Build with CAP_DECIM_EN defined to also exercise the decimation path.
module tb_sig_capture;
  import sig_capture_pkg::*;

  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          arm = 1'b0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  trig_level = 8'd128;
  logic [AW-1:0] rd_addr = '0;
`ifdef CAP_DECIM_EN
  logic [3:0]    decim = 4'd0;
`endif
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
  logic [AW:0]   wr_count;
  cap_state_t    dbg_state;

  always #5 clk = ~clk;

  sig_capture #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .arm        (arm),
    .trig_level (trig_level),
    .rd_addr    (rd_addr),
`ifdef CAP_DECIM_EN
    .decim      (decim),
`endif
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .wr_count   (wr_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // The capture window is a queue of stored samples; its length is wr_count.
  cap_state_t   m_state;
  int           m_last;      // last sample seen while armed, -1 if none
  int           m_k;         // en samples since trigger
  logic [W-1:0] m_win[$];
  logic [W-1:0] m_mem[DEPTH];
  bit           m_known[DEPTH];
  logic [W-1:0] m_rd;
  bit           m_rd_known;

  function automatic int eff_decim();
`ifdef CAP_DECIM_EN
    return int'(decim);
`else
    return 0;
`endif
  endfunction

  function automatic void m_store(input logic [W-1:0] d);
    m_mem[m_win.size()]   = d;
    m_known[m_win.size()] = 1'b1;
    m_win.push_back(d);
  endfunction

  function automatic void m_edge();
    if (rst) begin
      m_state    = IDLE;
      m_win.delete();
      m_last     = -1;
      m_rd       = '0;
      m_rd_known = 1'b1;
      return;
    end
    m_rd       = m_mem[rd_addr];
    m_rd_known = m_known[rd_addr];
    case (m_state)
      IDLE, DONE: begin
        if (arm) begin
          m_state = ARMED;
          m_win.delete();
          m_last  = -1;
        end
      end
      ARMED: begin
        if (en) begin
          if (m_last >= 0 && m_last < int'(trig_level) && int'(din) >= int'(trig_level)) begin
            m_store(din);
            m_k     = 0;
            m_state = CAPTURE;
          end
          m_last = int'(din);
        end
      end
      CAPTURE: begin
        if (en) begin
          m_k++;
          if (m_k % (eff_decim() + 1) == 0) begin
            m_store(din);
            if (m_win.size() == DEPTH) m_state = DONE;
          end
        end
      end
      default: m_state = IDLE;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit s_rst, input bit s_en, input bit s_arm,
                      input logic [W-1:0] s_din, input logic [AW-1:0] s_addr);
    rst     = s_rst;
    en      = s_en;
    arm     = s_arm;
    din     = s_din;
    rd_addr = s_addr;
    @(posedge clk);
    m_edge();
    #1;
    check("busy", int'(busy), int'(m_state == ARMED || m_state == CAPTURE));
    check("done", int'(done), int'(m_state == DONE));
    check("wr_count", int'(wr_count), m_win.size());
    check("state", int'(dbg_state), int'(m_state));
    if (m_rd_known) check("rd_data", int'(rd_data), int'(m_rd));
  endtask

  task automatic readback(input int addr, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    step(1'b0, 1'b0, 1'b0, '0, AW'(addr));
    check("readback", int'(rd_data), int'(exp_q.pop_front()));
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    bit           rst;
    bit           en;
    bit           arm;
    logic [W-1:0] din;
    bit           exp_busy;
    bit           exp_done;
    int           exp_cnt;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(bit r, bit e, bit a, logic [W-1:0] d, bit b, bit dn, int c);
    vec_t v;
    v.rst = r; v.en = e; v.arm = a; v.din = d;
    v.exp_busy = b; v.exp_done = dn; v.exp_cnt = c;
    return v;
  endfunction

  function automatic logic [W-1:0] sine_sample(input int k);
    real ph;
    ph = 6.283185307 * real'(k) / 20.0;
    return W'(128 + $rtoi(100.0 * $sin(ph)));
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int strobes;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    m_state = IDLE; m_last = -1; m_k = 0; m_rd = '0; m_rd_known = 1'b0;

    // Level 100: arm, sample at/above level, fall below, rise to trigger.
    tbl[0]  = mk(1, 0, 0, 8'd0,   0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 8'd50,  0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 8'd150, 1, 0, 0);
    tbl[3]  = mk(0, 1, 0, 8'd150, 1, 0, 0);
    tbl[4]  = mk(0, 1, 0, 8'd120, 1, 0, 0);
    tbl[5]  = mk(0, 1, 0, 8'd90,  1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 8'd200, 1, 0, 0);
    tbl[7]  = mk(0, 1, 0, 8'd100, 1, 0, 1);
    tbl[8]  = mk(0, 0, 0, 8'd5,   1, 0, 1);
    tbl[9]  = mk(0, 1, 0, 8'd7,   1, 0, 2);
    tbl[10] = mk(0, 1, 1, 8'd8,   1, 0, 3);
    tbl[11] = mk(1, 0, 0, 8'd0,   0, 0, 0);

    trig_level = 8'd100;
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].arm, tbl[i].din, '0);
      check("tbl_busy", int'(busy), int'(tbl[i].exp_busy));
      check("tbl_done", int'(done), int'(tbl[i].exp_done));
      check("tbl_cnt", int'(wr_count), tbl[i].exp_cnt);
    end

    // Reset / idle: ramp with no arm never starts anything.
    step(1, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);
    check("rst_rd_data", int'(rd_data), 0);
    for (int v = 0; v < 256; v++) begin
      step(0, 1, 0, W'(v), '0);
      check("idle_busy", int'(busy), 0);
    end

    // Basic capture at level 128 on a 120..200 ramp.
    trig_level = 8'd128;
    step(0, 0, 1, '0, '0);
    for (int v = 120; v <= 200; v++) begin
      step(0, 1, 0, W'(v), '0);
      if (v == 142) check("basic_done_early", int'(done), 0);
      if (v == 143) check("basic_done_at16", int'(done), 1);
    end
    for (int a = 0; a < DEPTH; a++) readback(a, W'(128 + a));

    // No false trigger from a stream already above the level.
    step(0, 0, 1, '0, '0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 8'd200, '0);
    check("nft_busy", int'(busy), 1);
    check("nft_cnt", int'(wr_count), 0);
    step(0, 1, 0, 8'd100, '0);
    check("nft_cnt_after_drop", int'(wr_count), 0);
    step(0, 1, 0, 8'd150, '0);
    check("nft_trig", int'(wr_count), 1);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 0, W'(151 + i), '0);
    check("nft_done", int'(done), 1);
    readback(0, 8'd150);

    // Gapped strobe: sine with en every third cycle.
    step(0, 0, 1, '0, '0);
    strobes = 0;
    for (int c = 0; c < 150; c++) begin
      if (c % 3 == 0) begin
        step(0, 1, 0, sine_sample(strobes), '0);
        strobes++;
      end else begin
        step(0, 0, 0, 8'hEE, '0);
      end
    end
    check("gap_done", int'(done), 1);
    check("gap_cnt", int'(wr_count), DEPTH);

    // Re-arm from DONE, then reset mid-capture at wr_count=5.
    step(0, 0, 1, '0, '0);
    check("rearm_done", int'(done), 0);
    check("rearm_busy", int'(busy), 1);
    step(0, 1, 0, 8'd100, '0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, W'(130 + i), '0);
    check("mid_cnt", int'(wr_count), 5);
    step(1, 1, 0, 8'd77, '0);
    check("rst_cnt", int'(wr_count), 0);
    check("rst_busy", int'(busy), 0);
    for (int a = 0; a < 5; a++) readback(a, W'(130 + a));

`ifdef CAP_DECIM_EN
    // Decimation by 3 on a ramp triggering at 128.
    decim = 4'd2;
    step(0, 0, 1, '0, '0);
    for (int v = 120; v <= 200; v++) step(0, 1, 0, W'(v), '0);
    check("dec_done", int'(done), 1);
    for (int a = 0; a < DEPTH; a++) readback(a, W'(128 + 3 * a));
    decim = 4'd0;
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) trig_level = W'($urandom_range(20, 235));
`ifdef CAP_DECIM_EN
      if (m_state != CAPTURE && $urandom_range(0, 99) == 0) decim = 4'($urandom_range(0, 3));
`endif
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0,
           W'($urandom_range(0, 255)),
           AW'($urandom_range(0, DEPTH - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the sequence is fixed-length, so this only guards a stuck clock.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
